// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single push port of a DW-bit fifo among NREQ producers.
//   Grants one word per cycle in round-robin order. Each producer uses a
//   valid/ready handshake that completes in the same cycle as the grant.
//   Also sequences a fifo flush: it stops granting, pulses fifo_dump for one
//   cycle, and then waits for fifo_empty before granting again.
//
// Parameters
//   DW    data width, matches the fifo din
//   NREQ  number of requesters (2..8)
//   CW    width of the accepted-word counter
//
// Ports
//   clk         single clock, all logic on posedge
//   rst         synchronous active-high reset
//   req_valid   per-requester valid
//   req_data    packed requester data, requester 0 in the LSBs
//   req_ready   one-hot or zero; word i is accepted when valid[i] & ready[i]
//   fifo_full   fifo full flag
//   fifo_empty  fifo empty flag
//   fifo_push   fifo push strobe
//   fifo_din    fifo write data
//   fifo_dump   one-cycle fifo flush strobe
//   flush_req   level or pulse flush request (sampled in RUN only)
//   flush_busy  high while a flush is in progress
//   grant_id    index of the current grant, valid when fifo_push=1
//   push_cnt    words pushed since reset or the last flush; wraps silently
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter  int DW   = 32,
  parameter  int NREQ = 4,
  parameter  int CW   = 16,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  output logic               fifo_push,
  output logic [DW-1:0]      fifo_din,
  output logic               fifo_dump,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic [GW-1:0]      grant_id,
  output logic [CW-1:0]      push_cnt
);

  typedef enum logic [1:0] {
    RUN,
    DUMP,
    WAIT_EMPTY
  } state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;

  // Round-robin search results.
  logic          found;
  logic [GW-1:0] win;
  int            idx;
  logic          grant;

  // ---------------------------------------------------------------------------
  // Round-robin search: scan upward from rr_ptr, wrapping at NREQ (not at
  // 2^GW), so indices >= NREQ are never considered.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the loop; otherwise a path
    // that never assigns it would infer a latch.
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
  end

  // A grant happens only in RUN, outside reset, with room in the fifo and no
  // flush being requested this cycle. The handshake is zero latency, so the
  // handshake outputs are decoded from the current state rather than
  // registered.
  assign grant = (state == RUN) && !rst && !fifo_full && !flush_req && found;

  always_comb begin
    req_ready = '0;
    fifo_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == GW'(i)) begin
        req_ready[i] = grant;
        fifo_din     = req_data[i*DW +: DW];
      end
    end
  end

  assign fifo_push  = grant;
  assign grant_id   = win;
  assign fifo_dump  = (state == DUMP) && !rst;
  assign flush_busy = (state != RUN);

  // ---------------------------------------------------------------------------
  // Control FSM, round-robin pointer and accepted-word counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= RUN;
      rr_ptr   <= '0;
      push_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (flush_req) begin
            state <= DUMP;
          end else if (grant) begin
            // The winner moves to the back of the line. On a full fifo no
            // grant happens, so the pending winner keeps its priority.
            rr_ptr   <= (win == GW'(NREQ - 1)) ? '0 : win + 1'b1;
            push_cnt <= push_cnt + 1'b1;
          end
        end
        DUMP: begin
          push_cnt <= '0;
          state    <= WAIT_EMPTY;
        end
        WAIT_EMPTY: begin
          // flush_req is ignored here; rr_ptr is left untouched across the
          // flush.
          if (fifo_empty) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (DW=32, NREQ=4, CW=16). A small
//   512-entry fifo model supplies full/empty and reads back the pushed words.
//   Inputs change on the falling edge. Outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int DW    = 32;
  localparam int NREQ  = 4;
  localparam int CW    = 16;
  localparam int DEPTH = 512;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic [DW-1:0]     fifo_din;
  logic              fifo_dump;
  logic              flush_req = 1'b0;
  logic              flush_busy;
  logic [1:0]        grant_id;
  logic [CW-1:0]     push_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DW(DW), .NREQ(NREQ), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_push  (fifo_push),
    .fifo_din   (fifo_din),
    .fifo_dump  (fifo_dump),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .grant_id   (grant_id),
    .push_cnt   (push_cnt)
  );

  // ---------------------------------------------------------------------------
  // FIFO model
  // ---------------------------------------------------------------------------
  logic [DW-1:0] fmem [0:DEPTH-1];
  int            fcount = 0;
  int            wp = 0;
  int            rp = 0;
  logic          pop = 1'b0;
  logic          hold_not_empty = 1'b0;  // stretches WAIT_EMPTY on demand
  logic [DW-1:0] head;

  assign fifo_full  = (fcount == DEPTH);
  assign fifo_empty = (fcount == 0) && !hold_not_empty;
  assign head       = fmem[rp];

  always @(posedge clk) begin
    if (fifo_dump) begin
      fcount <= 0;
      wp     <= 0;
      rp     <= 0;
    end else begin
      if (fifo_push && fcount < DEPTH) begin
        fmem[wp] <= fifo_din;
        wp       <= (wp + 1) % DEPTH;
      end
      if (pop && fcount > 0) rp <= (rp + 1) % DEPTH;
      fcount <= fcount + ((fifo_push && fcount < DEPTH) ? 1 : 0)
                       - ((pop && fcount > 0) ? 1 : 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 4'b0000 || fifo_push !== 1'b0 || fifo_dump !== 1'b0) begin
      errors++;
      $display("FAIL reset_mask: ready=%b push=%b dump=%b, expected 0000/0/0",
               req_ready, fifo_push, fifo_dump);
    end
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || fifo_push !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b push=%b, expected 0000/0", req_ready, fifo_push);
    end
    checks++;
    if (push_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_push_cnt: got %0d expected 0", push_cnt);
    end
    checks++;
    if (flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush_busy: got %b expected 0", flush_busy);
    end
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo_flags: empty=%b full=%b expected 1/0", fifo_empty, fifo_full);
    end
  endtask

  task automatic test_single_requester();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid          = 4'b0100;
      req_data[64 +: 32] = 32'h10 + k;
      #1;
      checks++;
      if (fifo_push !== 1'b1 || grant_id !== 2'd2 || req_ready !== 4'b0100 ||
          fifo_din !== 32'h10 + k) begin
        errors++;
        $display("FAIL single_grant%0d: push=%b id=%0d ready=%b din=%h expected 1/2/0100/%h",
                 k, fifo_push, grant_id, req_ready, fifo_din, 32'h10 + k);
      end
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (push_cnt !== 16'd2 || fifo_push !== 1'b0) begin
      errors++;
      $display("FAIL single_push_cnt: cnt=%0d push=%b expected 2/0", push_cnt, fifo_push);
    end
    for (int k = 0; k < 2; k++) begin
      pop = 1'b1;
      #1;
      checks++;
      if (fifo_empty !== 1'b0 || head !== 32'h10 + k) begin
        errors++;
        $display("FAIL single_readback%0d: empty=%b data=%h expected 0/%h",
                 k, fifo_empty, head, 32'h10 + k);
      end
      @(negedge clk);
    end
    pop = 1'b0;
  endtask

  task automatic test_round_robin();
    int            cnt [NREQ];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] word;
    int            exp_id;
    // Fresh reset so the pointer starts at requester 0.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++)
        req_data[i*DW +: DW] = 32'hA000_0000 | (i << 8) | cnt[i];
      #1;
      exp_id = c % NREQ;
      word   = 32'hA000_0000 | (exp_id << 8) | cnt[exp_id];
      checks++;
      if (grant_id !== 2'(exp_id) || req_ready !== 4'(1 << exp_id) ||
          fifo_push !== 1'b1 || fifo_din !== word) begin
        errors++;
        $display("FAIL rr_cycle%0d: id=%0d ready=%b din=%h expected %0d/%b/%h",
                 c, grant_id, req_ready, fifo_din, exp_id, 4'(1 << exp_id), word);
      end
      exp_q.push_back(word);
      cnt[exp_id]++;
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    checks++;
    if (push_cnt !== 16'd8) begin
      errors++;
      $display("FAIL rr_push_cnt: got %0d expected 8", push_cnt);
    end
    for (int c = 0; c < 8; c++) begin
      pop  = 1'b1;
      word = exp_q.pop_front();
      #1;
      checks++;
      if (head !== word) begin
        errors++;
        $display("FAIL rr_readback%0d: got %h expected %h", c, head, word);
      end
      @(negedge clk);
    end
    pop = 1'b0;
  endtask

  task automatic test_full();
    int            npush = 0;
    int            nbad  = 0;
    logic [DW-1:0] exp_word;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      req_valid         = 4'b0001;
      req_data[0 +: 32] = 32'h5000_0000 + k;
      #1;
      if (fifo_push === 1'b1) npush++;
    end
    checks++;
    if (npush !== DEPTH) begin
      errors++;
      $display("FAIL full_fill_count: got %0d pushes expected %0d", npush, DEPTH);
    end
    @(negedge clk);
    req_valid          = 4'b0011;
    req_data[32 +: 32] = 32'h6000_0001;
    #1;
    checks++;
    if (fifo_full !== 1'b1 || req_ready !== 4'b0000 || fifo_push !== 1'b0) begin
      errors++;
      $display("FAIL full_stall: full=%b ready=%b push=%b expected 1/0000/0",
               fifo_full, req_ready, fifo_push);
    end
    @(negedge clk);
    pop = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || head !== 32'h5000_0000) begin
      errors++;
      $display("FAIL full_pop_cycle: ready=%b head=%h expected 0000/50000000", req_ready, head);
    end
    @(negedge clk);
    pop = 1'b0;
    #1;
    // Pointer was held at 1 while full, so requester 1 wins over requester 0.
    checks++;
    if (grant_id !== 2'd1 || req_ready !== 4'b0010 || fifo_push !== 1'b1 ||
        fifo_din !== 32'h6000_0001) begin
      errors++;
      $display("FAIL full_resume_grant: id=%0d ready=%b push=%b din=%h expected 1/0010/1/60000001",
               grant_id, req_ready, fifo_push, fifo_din);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (push_cnt !== 16'd521) begin
      errors++;
      $display("FAIL full_push_cnt: got %0d expected 521", push_cnt);
    end
    for (int k = 0; k < DEPTH; k++) begin
      pop = 1'b1;
      #1;
      exp_word = (k < DEPTH - 1) ? 32'h5000_0001 + k : 32'h6000_0001;
      if (head !== exp_word) nbad++;
      @(negedge clk);
    end
    pop = 1'b0;
    #1;
    checks++;
    if (nbad !== 0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL full_drain: %0d bad words, empty=%b, expected 0 bad and empty=1",
               nbad, fifo_empty);
    end
  endtask

  task automatic test_flush();
    int n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid          = 4'b1000;
      req_data[96 +: 32] = 32'h7000_0000 + k;
      #1;
      if (fifo_push === 1'b1 && grant_id === 2'd3) n++;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL flush_load: got %0d pushes from req 3 expected 5", n);
    end
    @(negedge clk);
    req_valid = '0;
    flush_req = 1'b1;
    #1;
    checks++;
    if (push_cnt !== 16'd526 || flush_busy !== 1'b0 || fifo_push !== 1'b0) begin
      errors++;
      $display("FAIL flush_request_cycle: cnt=%0d busy=%b push=%b expected 526/0/0",
               push_cnt, flush_busy, fifo_push);
    end
    // flush_req stays high as a level. It must not start a second dump.
    @(negedge clk);
    req_valid      = 4'b1111;
    hold_not_empty = 1'b1;
    #1;
    checks++;
    if (fifo_dump !== 1'b1 || flush_busy !== 1'b1 || req_ready !== 4'b0000 ||
        fifo_push !== 1'b0) begin
      errors++;
      $display("FAIL flush_dump_cycle: dump=%b busy=%b ready=%b push=%b expected 1/1/0000/0",
               fifo_dump, flush_busy, req_ready, fifo_push);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      checks++;
      if (flush_busy !== 1'b1 || fifo_dump !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL flush_wait%0d: busy=%b dump=%b ready=%b expected 1/0/0000",
                 j, flush_busy, fifo_dump, req_ready);
      end
    end
    @(negedge clk);
    flush_req      = 1'b0;
    req_valid      = '0;
    hold_not_empty = 1'b0;
    #1;
    checks++;
    if (flush_busy !== 1'b1 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_wait_exit: busy=%b empty=%b expected 1/1", flush_busy, fifo_empty);
    end
    @(negedge clk); #1;
    checks++;
    if (flush_busy !== 1'b0 || push_cnt !== 16'd0) begin
      errors++;
      $display("FAIL flush_done: busy=%b cnt=%0d expected 0/0", flush_busy, push_cnt);
    end
  endtask

  task automatic test_flush_collision();
    @(negedge clk);
    req_valid         = 4'b0001;
    req_data[0 +: 32] = 32'h0000_00F0;
    flush_req         = 1'b1;
    #1;
    checks++;
    if (fifo_push !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL collide_no_push: push=%b ready=%b expected 0/0000", fifo_push, req_ready);
    end
    @(negedge clk);
    flush_req = 1'b0;
    #1;
    checks++;
    if (fifo_dump !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL collide_dump: dump=%b ready=%b expected 1/0000", fifo_dump, req_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (flush_busy !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL collide_wait: busy=%b ready=%b expected 1/0000", flush_busy, req_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (fifo_push !== 1'b1 || grant_id !== 2'd0 || fifo_din !== 32'h0000_00F0) begin
      errors++;
      $display("FAIL collide_late_push: push=%b id=%0d din=%h expected 1/0/000000f0",
               fifo_push, grant_id, fifo_din);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (push_cnt !== 16'd1) begin
      errors++;
      $display("FAIL collide_push_cnt: got %0d expected 1", push_cnt);
    end
  endtask

  task automatic test_reset_mid_flush();
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    rst       = 1'b1;
    #1;
    checks++;
    if (fifo_dump !== 1'b0) begin
      errors++;
      $display("FAIL midflush_dump_masked: got %b expected 0", fifo_dump);
    end
    @(negedge clk);
    rst                = 1'b0;
    req_valid          = 4'b1001;
    req_data[0 +: 32]  = 32'h0000_00B0;
    req_data[96 +: 32] = 32'h0000_00B3;
    #1;
    // The pointer was 1 before reset (requester 3 would win). After reset it
    // is 0.
    checks++;
    if (flush_busy !== 1'b0 || grant_id !== 2'd0 || fifo_push !== 1'b1 ||
        push_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midflush_recover: busy=%b id=%0d push=%b cnt=%0d expected 0/0/1/0",
               flush_busy, grant_id, fifo_push, push_cnt);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_round_robin();
    test_full();
    test_flush();
    test_flush_collision();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
